// File: rtl/sync_filter_if.sv
// Channel bus for sync_filter: tuning input, raw pins in, filtered levels and edge pulses out.
interface sync_filter_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CNT_BITS = 4
) ();
    logic [CNT_BITS-1:0] filt_len;
    logic [WIDTH-1:0]    datain;
    logic [WIDTH-1:0]    dataout;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    fall;
    logic                changed;

    // Producer side: drives pins and threshold, observes conditioned outputs.
    modport master (
        output filt_len,
        output datain,
        input  dataout,
        input  rise,
        input  fall,
        input  changed
    );

    // Conditioner side.
    modport slave (
        input  filt_len,
        input  datain,
        output dataout,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: per-channel synchronizer followed by a
// runtime-tunable stability filter, with registered rise/fall/changed pulses.
module sync_filter #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      CNT_BITS    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input logic          clk,
    input logic          reset,
    sync_filter_if.slave bus
);

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    synced;
    logic [CNT_BITS-1:0] cnt_q  [WIDTH];
    logic [CNT_BITS-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0]    dout_q;
    logic [WIDTH-1:0]    dout_d;
    logic [WIDTH-1:0]    upd;
    logic [WIDTH-1:0]    rise_q;
    logic [WIDTH-1:0]    fall_q;
    logic                changed_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // Per-channel stability filter: output follows synced only after a long enough mismatch run.
    always_comb begin
        dout_d = dout_q;
        upd    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (synced[i] == dout_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= bus.filt_len) begin
                dout_d[i] = synced[i];
                cnt_d[i]  = '0;
                upd[i]    = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end
        end
    end

    // Synchronizer chain, counters, filtered level and edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= RESET_VAL;
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            dout_q    <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q[0] <= bus.datain;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dout_q    <= dout_d;
            rise_q    <= upd & synced;
            fall_q    <= upd & ~synced;
            changed_q <= |upd;
        end
    end

    assign bus.dataout = dout_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_sync_filter.sv
// Randomized and directed bench for sync_filter against a run-length reference model.
module tb_sync_filter;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_BITS    = 4;
    localparam logic [7:0]  RV          = 8'h00;

    logic clk = 1'b0;
    logic reset;

    sync_filter_if #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) bus ();

    sync_filter #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_BITS(CNT_BITS), .RESET_VAL(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: pins reach the filter SYNC_STAGES edges late; a channel flips once
    // its synced value has disagreed with the output on more than filt_len consecutive edges.
    logic [7:0] m_pipe [$];
    logic [7:0] m_out, m_rise, m_fall;
    logic       m_chg;
    int         m_run [WIDTH];

    always @(posedge clk) begin
        logic [7:0] syn;
        if (reset) begin
            m_pipe = {};
            repeat (SYNC_STAGES) m_pipe.push_back(RV);
            m_out  = RV;
            m_rise = '0;
            m_fall = '0;
            m_chg  = 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) m_run[i] = 0;
        end else begin
            syn = m_pipe.pop_back();
            m_pipe.push_front(bus.datain);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (syn[i] == m_out[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > int'(bus.filt_len)) begin
                        m_out[i] = syn[i];
                        if (syn[i]) m_rise[i] = 1'b1;
                        else        m_fall[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end
            end
            m_chg = |(m_rise | m_fall);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and compare all outputs against the model.
    task automatic tick();
        @(posedge clk);
        #1;
        check("dataout", 32'(bus.dataout), 32'(m_out));
        check("rise",    32'(bus.rise),    32'(m_rise));
        check("fall",    32'(bus.fall),    32'(m_fall));
        check("changed", 32'(bus.changed), 32'(m_chg));
    endtask

    // Drive one channel and count edges until dataout follows (bounded).
    task automatic latency(input string tag, input int ch, input logic val, input int exp);
        int k;
        bus.datain[ch] = val;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.dataout[ch] !== val && k < 30);
        check(tag, 32'(k), 32'(exp));
    endtask

    initial begin
        logic [7:0] mask;
        reset        = 1'b1;
        bus.datain   = 8'hFF;
        bus.filt_len = '0;

        // Reset hold with all pins high
        repeat (3) tick();
        check("rst_dout",  32'(bus.dataout), 32'h00);
        check("rst_rise",  32'(bus.rise),    32'h00);
        check("rst_fall",  32'(bus.fall),    32'h00);
        check("rst_chg",   32'(bus.changed), 32'h0);
        reset = 1'b0;
        tick();
        check("rel_dout",  32'(bus.dataout), 32'h00);
        check("rel_chg",   32'(bus.changed), 32'h0);

        // Bypass filter: rise after SYNC_STAGES+1 edges, one-cycle pulse
        bus.datain = 8'h00;
        repeat (6) tick();
        latency("lat_fl0", 0, 1'b1, 3);
        check("bypass_rise", 32'(bus.rise[0]), 32'h1);
        check("bypass_chg",  32'(bus.changed), 32'h1);
        tick();
        check("bypass_rise_end", 32'(bus.rise[0]), 32'h0);
        check("bypass_chg_end",  32'(bus.changed), 32'h0);

        // Short glitch suppressed, then full-latency rise and fall
        bus.filt_len = 4'd3;
        bus.datain[1] = 1'b1;
        repeat (3) tick();
        bus.datain[1] = 1'b0;
        repeat (8) tick();
        check("glitch_dout", 32'(bus.dataout[1]), 32'h0);
        latency("lat_fl3_rise", 1, 1'b1, 6);
        check("fl3_rise", 32'(bus.rise[1]), 32'h1);
        latency("lat_fl3_fall", 1, 1'b0, 6);
        check("fl3_fall", 32'(bus.fall[1]), 32'h1);

        // Threshold lowered below the running count fires on the next edge
        bus.filt_len  = 4'd7;
        bus.datain[4] = 1'b1;
        repeat (6) tick();
        check("fl_hold", 32'(bus.dataout[4]), 32'h0);
        bus.filt_len = 4'd1;
        tick();
        check("fl_drop_dout", 32'(bus.dataout[4]), 32'h1);
        check("fl_drop_rise", 32'(bus.rise[4]), 32'h1);

        // Simultaneous rise/fall on two channels
        bus.filt_len = 4'd2;
        bus.datain   = 8'h08;
        repeat (10) tick();
        check("sim_pre", 32'(bus.dataout), 32'h08);
        bus.datain = 8'h04;
        begin
            int k;
            k = 0;
            do begin
                tick();
                k++;
            end while (bus.changed !== 1'b1 && k < 20);
            check("sim_lat",  32'(k), 32'd5);
            check("sim_rise", 32'(bus.rise), 32'h04);
            check("sim_fall", 32'(bus.fall), 32'h08);
        end

        // Reset mid-count discards the count; full latency after release
        bus.filt_len  = 4'd5;
        bus.datain[5] = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_dout", 32'(bus.dataout[5]), 32'h0);
        check("midrst_chg",  32'(bus.changed), 32'h0);
        bus.datain = 8'h20;
        reset = 1'b0;
        latency("lat_after_rst", 5, 1'b1, 8);

        // Random pins, thresholds and occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            mask  = '0;
            for (int b = 0; b < int'(WIDTH); b++)
                if ($urandom_range(0, 5) == 0) mask[b] = 1'b1;
            bus.datain = bus.datain ^ mask;
            if ($urandom_range(0, 39) == 0)
                bus.filt_len = CNT_BITS'($urandom_range(0, 6));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
